// File: rtl/seven_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_ctrl
//
// Time-multiplexed scan controller for an N-digit common-anode 7-segment
// display. One external hex-to-7-segment decoder is shared by all digits:
// the controller presents the current digit code on dec_a and registers the
// decoder's answer (dec_y) onto seg_n. Every digit slot starts with a blanking
// window (all anodes off) to suppress ghosting while the decoder settles.
// Display data is double-buffered: a load goes to a pending buffer and is
// committed to the displayed frame only at the end of a full scan frame.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   load      1-cycle pulse: capture value/dp_in into the pending buffer
//   value     hex digits, [3:0] = digit 0 (rightmost)
//   dp_in     decimal point per digit, 1 = lit
//   blank_lz  1 = blank leading-zero digits (digit 0 always shown), live
//   load_ack  1-cycle pulse when pending data is committed to the display
//   dec_a     digit code to the shared decoder (registered)
//   dec_y     active-low segments from the decoder (combinational return)
//   seg_n     active-low segments to the display (registered)
//   dp_n      active-low decimal point (registered)
//   an_n      active-low digit enables (registered)
// ---------------------------------------------------------------------------
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 500,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic                    load_ack,
  output logic [3:0]              dec_a,
  input  logic [6:0]              dec_y,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg;
  logic [IDX_W-1:0]        idx_reg;

  logic [4*NUM_DIGITS-1:0] frame_val_reg, pend_val_reg;
  logic [NUM_DIGITS-1:0]   frame_dp_reg, pend_dp_reg;
  logic                    pend_valid_reg;
  logic                    load_ack_reg;

  logic [3:0]              dec_a_reg;
  logic [6:0]              seg_reg, seg_next;
  logic                    dp_reg, dp_next;
  logic [NUM_DIGITS-1:0]   an_reg, an_next;

  logic                    wrap;
  logic                    frame_end;
  logic [3:0]              digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    seen_nonzero;

  assign wrap      = (cnt_reg == CNT_W'(SCAN_DIV - 1));
  assign frame_end = wrap && (idx_reg == IDX_W'(NUM_DIGITS - 1));

  // Per-digit view of the displayed frame and one-hot select of the digit
  // currently being scanned.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit[gi]  = frame_val_reg[4*gi +: 4];
      assign an_sel[gi] = (idx_reg == IDX_W'(gi));
    end
  endgenerate

  // Leading-zero mask: bit k set when digits k..N-1 are all zero. Walk from
  // the most significant digit down; digit 0 is never part of the mask.
  always_comb begin
    lz_mask      = '0;
    seen_nonzero = 1'b0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      seen_nonzero = seen_nonzero | (digit[k] != 4'h0);
      lz_mask[k]   = !seen_nonzero;
    end
  end

  // Slot counter and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      idx_reg <= '0;
    end else if (wrap) begin
      cnt_reg <= '0;
      idx_reg <= (idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= BLANK;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and next display outputs. The state tracks the counter so
  // that SHOW holds exactly while cnt >= BLANK_CYC. The display is only
  // driven on cycles that stay in SHOW: the first SHOW cycle is when dec_y
  // becomes trustworthy for registering, and the wrap cycle must already
  // blank so the old digit never bleeds into the next slot.
  always_comb begin
    state_next = state_reg;
    an_next    = '1;
    seg_next   = 7'h7F;
    dp_next    = 1'b1;
    case (state_reg)
      BLANK: if (cnt_reg == CNT_W'(BLANK_CYC - 1)) state_next = SHOW;
      SHOW:  if (wrap) state_next = BLANK;
      default: state_next = BLANK;
    endcase
    if ((state_reg == SHOW) && (state_next == SHOW)) begin
      an_next  = ~an_sel;
      seg_next = (blank_lz && lz_mask[idx_reg]) ? 7'h7F : dec_y;
      dp_next  = ~frame_dp_reg[idx_reg];
    end
  end

  // Decoder address and display output registers. dec_a follows the current
  // digit every cycle, including BLANK, so the decoder has settled by SHOW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_a_reg <= 4'h0;
      seg_reg   <= 7'h7F;
      dp_reg    <= 1'b1;
      an_reg    <= '1;
    end else begin
      dec_a_reg <= digit[idx_reg];
      seg_reg   <= seg_next;
      dp_reg    <= dp_next;
      an_reg    <= an_next;
    end
  end

  // Double buffer. A load landing on the commit cycle bypasses the pending
  // buffer so the latest value is never lost behind an older pending one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_val_reg  <= '0;
      frame_dp_reg   <= '0;
      pend_val_reg   <= '0;
      pend_dp_reg    <= '0;
      pend_valid_reg <= 1'b0;
      load_ack_reg   <= 1'b0;
    end else begin
      load_ack_reg <= 1'b0;
      if (frame_end && load) begin
        frame_val_reg  <= value;
        frame_dp_reg   <= dp_in;
        pend_valid_reg <= 1'b0;
        load_ack_reg   <= 1'b1;
      end else if (frame_end && pend_valid_reg) begin
        frame_val_reg  <= pend_val_reg;
        frame_dp_reg   <= pend_dp_reg;
        pend_valid_reg <= 1'b0;
        load_ack_reg   <= 1'b1;
      end else if (load) begin
        pend_val_reg   <= value;
        pend_dp_reg    <= dp_in;
        pend_valid_reg <= 1'b1;
      end
    end
  end

  assign dec_a    = dec_a_reg;
  assign seg_n    = seg_reg;
  assign dp_n     = dp_reg;
  assign an_n     = an_reg;
  assign load_ack = load_ack_reg;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for seven_seg_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2, 4 digits.
// Cycle numbering: cycle 0 is the interval right after reset release, so in
// cycle c the slot counter is c%8 and the digit index is (c/8)%4. An anode is
// on for counter values 3..7. A frame is 32 cycles; a commit at the end of
// cycle 32k-1 shows load_ack in cycle 32k and the new frame from then on.
// ---------------------------------------------------------------------------
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        load_ack;
  logic [3:0]  dec_a;
  logic [6:0]  dec_y;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Expected per-digit segments / dps before and after a commit point.
  logic [6:0] seg_old [4];
  logic [6:0] seg_new [4];
  logic [3:0] dp_old;
  logic [3:0] dp_new;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS(4),
    .SCAN_DIV  (8),
    .BLANK_CYC (2),
    .CNT_W     (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .value   (value),
    .dp_in   (dp_in),
    .blank_lz(blank_lz),
    .load_ack(load_ack),
    .dec_a   (dec_a),
    .dec_y   (dec_y),
    .seg_n   (seg_n),
    .dp_n    (dp_n),
    .an_n    (an_n)
  );

  always #5 clk = ~clk;

  // Behavioural hex-to-7-segment decoder, active-low, gfedcba.
  always_comb begin
    case (dec_a)
      4'h0: dec_y = 7'h40;
      4'h1: dec_y = 7'h79;
      4'h2: dec_y = 7'h24;
      4'h3: dec_y = 7'h30;
      4'h4: dec_y = 7'h19;
      4'h5: dec_y = 7'h12;
      4'h6: dec_y = 7'h02;
      4'h7: dec_y = 7'h78;
      4'h8: dec_y = 7'h00;
      4'h9: dec_y = 7'h10;
      4'hA: dec_y = 7'h08;
      4'hB: dec_y = 7'h03;
      4'hC: dec_y = 7'h46;
      4'hD: dec_y = 7'h21;
      4'hE: dec_y = 7'h06;
      default: dec_y = 7'h0E;
    endcase
  end

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [3:0] exp_an(input int cy);
    if ((cy % 8) >= 3) return ~(4'b0001 << ((cy / 8) % 4));
    return 4'hF;
  endfunction

  function automatic logic [6:0] exp_seg(input int cy, input int sw);
    int d = (cy / 8) % 4;
    if ((cy % 8) < 3) return 7'h7F;
    return (cy >= sw) ? seg_new[d] : seg_old[d];
  endfunction

  function automatic logic exp_dp(input int cy, input int sw);
    int d = (cy / 8) % 4;
    if ((cy % 8) < 3) return 1'b1;
    return (cy >= sw) ? ~dp_new[d] : ~dp_old[d];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 5;
    if (an_n !== 4'hF) begin failures++; $display("FAIL reset an_n got=%b exp=1111", an_n); end
    if (seg_n !== 7'h7F) begin failures++; $display("FAIL reset seg_n got=%h exp=7f", seg_n); end
    if (dp_n !== 1'b1) begin failures++; $display("FAIL reset dp_n got=%b exp=1", dp_n); end
    if (load_ack !== 1'b0) begin failures++; $display("FAIL reset load_ack got=%b exp=0", load_ack); end
    if (dec_a !== 4'h0) begin failures++; $display("FAIL reset dec_a got=%h exp=0", dec_a); end
    rst_n = 1'b1;
    cyc = 0;
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  // Two frames of zeros: first with blank_lz=0, then with blank_lz=1.
  task automatic test_scan();
    logic [3:0] e_an; logic [6:0] e_seg; logic e_dp;
    for (int i = 0; i < 4; i++) begin
      seg_old[i] = 7'h40;
      seg_new[i] = (i == 0) ? 7'h40 : 7'h7F;
    end
    dp_old = 4'h0; dp_new = 4'h0;
    while (cyc < 64) begin
      e_an = exp_an(cyc); e_seg = exp_seg(cyc, 32); e_dp = exp_dp(cyc, 32);
      checks += 4;
      if (an_n !== e_an) begin failures++; $display("FAIL scan an_n cyc=%0d got=%b exp=%b", cyc, an_n, e_an); end
      if (seg_n !== e_seg) begin failures++; $display("FAIL scan seg_n cyc=%0d got=%h exp=%h", cyc, seg_n, e_seg); end
      if (dp_n !== e_dp) begin failures++; $display("FAIL scan dp_n cyc=%0d got=%b exp=%b", cyc, dp_n, e_dp); end
      if (load_ack !== 1'b0) begin failures++; $display("FAIL scan load_ack cyc=%0d got=%b exp=0", cyc, load_ack); end
      if (cyc == 32) blank_lz = 1'b1;
      step();
    end
    $display("test_scan done checks=%0d failures=%0d", checks, failures);
  endtask

  // Mid-frame load of 12AF, dp on digit 2; visible only after the frame end.
  task automatic test_load();
    logic [3:0] e_an; logic [6:0] e_seg; logic e_dp; logic e_ack;
    for (int i = 0; i < 4; i++) seg_old[i] = seg_new[i];
    dp_old = dp_new;
    seg_new[0] = 7'h0E; seg_new[1] = 7'h08; seg_new[2] = 7'h24; seg_new[3] = 7'h79;
    dp_new = 4'b0100;
    value = 16'h12AF; dp_in = 4'b0100;
    while (cyc < 128) begin
      e_an = exp_an(cyc); e_seg = exp_seg(cyc, 96); e_dp = exp_dp(cyc, 96); e_ack = (cyc == 96);
      checks += 4;
      if (an_n !== e_an) begin failures++; $display("FAIL load an_n cyc=%0d got=%b exp=%b", cyc, an_n, e_an); end
      if (seg_n !== e_seg) begin failures++; $display("FAIL load seg_n cyc=%0d got=%h exp=%h", cyc, seg_n, e_seg); end
      if (dp_n !== e_dp) begin failures++; $display("FAIL load dp_n cyc=%0d got=%b exp=%b", cyc, dp_n, e_dp); end
      if (load_ack !== e_ack) begin failures++; $display("FAIL load load_ack cyc=%0d got=%b exp=%b", cyc, load_ack, e_ack); end
      load = (cyc == 74);
      step();
    end
    $display("test_load done checks=%0d failures=%0d", checks, failures);
  endtask

  // 0050 with blank_lz=1: digits 3,2 blanked; dp on blanked digit 3 still lit.
  task automatic test_leading_zero();
    logic [3:0] e_an; logic [6:0] e_seg; logic e_dp; logic e_ack;
    for (int i = 0; i < 4; i++) seg_old[i] = seg_new[i];
    dp_old = dp_new;
    seg_new[0] = 7'h40; seg_new[1] = 7'h12; seg_new[2] = 7'h7F; seg_new[3] = 7'h7F;
    dp_new = 4'b1000;
    value = 16'h0050; dp_in = 4'b1000;
    while (cyc < 192) begin
      e_an = exp_an(cyc); e_seg = exp_seg(cyc, 160); e_dp = exp_dp(cyc, 160); e_ack = (cyc == 160);
      checks += 4;
      if (an_n !== e_an) begin failures++; $display("FAIL lz an_n cyc=%0d got=%b exp=%b", cyc, an_n, e_an); end
      if (seg_n !== e_seg) begin failures++; $display("FAIL lz seg_n cyc=%0d got=%h exp=%h", cyc, seg_n, e_seg); end
      if (dp_n !== e_dp) begin failures++; $display("FAIL lz dp_n cyc=%0d got=%b exp=%b", cyc, dp_n, e_dp); end
      if (load_ack !== e_ack) begin failures++; $display("FAIL lz load_ack cyc=%0d got=%b exp=%b", cyc, load_ack, e_ack); end
      load = (cyc == 130);
      step();
    end
    $display("test_leading_zero done checks=%0d failures=%0d", checks, failures);
  endtask

  // Two loads in one frame: single ack, latest value (2222) shown.
  task automatic test_back_to_back();
    logic [3:0] e_an; logic [6:0] e_seg; logic e_dp; logic e_ack;
    for (int i = 0; i < 4; i++) begin
      seg_old[i] = seg_new[i];
      seg_new[i] = 7'h24;
    end
    dp_old = dp_new; dp_new = 4'b0000;
    while (cyc < 256) begin
      e_an = exp_an(cyc); e_seg = exp_seg(cyc, 224); e_dp = exp_dp(cyc, 224); e_ack = (cyc == 224);
      checks += 4;
      if (an_n !== e_an) begin failures++; $display("FAIL b2b an_n cyc=%0d got=%b exp=%b", cyc, an_n, e_an); end
      if (seg_n !== e_seg) begin failures++; $display("FAIL b2b seg_n cyc=%0d got=%h exp=%h", cyc, seg_n, e_seg); end
      if (dp_n !== e_dp) begin failures++; $display("FAIL b2b dp_n cyc=%0d got=%b exp=%b", cyc, dp_n, e_dp); end
      if (load_ack !== e_ack) begin failures++; $display("FAIL b2b load_ack cyc=%0d got=%b exp=%b", cyc, load_ack, e_ack); end
      value = (cyc < 200) ? 16'h1111 : 16'h2222;
      dp_in = (cyc < 200) ? 4'b0001 : 4'b0000;
      load  = (cyc == 195) || (cyc == 210);
      step();
    end
    $display("test_back_to_back done checks=%0d failures=%0d", checks, failures);
  endtask

  // Load exactly on the commit cycle: ack next cycle, no second ack later.
  task automatic test_commit_edge();
    logic [3:0] e_an; logic [6:0] e_seg; logic e_dp; logic e_ack;
    for (int i = 0; i < 4; i++) begin
      seg_old[i] = seg_new[i];
      seg_new[i] = 7'h30;
    end
    dp_old = dp_new; dp_new = 4'b1001;
    value = 16'h3333; dp_in = 4'b1001;
    while (cyc < 352) begin
      e_an = exp_an(cyc); e_seg = exp_seg(cyc, 288); e_dp = exp_dp(cyc, 288); e_ack = (cyc == 288);
      checks += 4;
      if (an_n !== e_an) begin failures++; $display("FAIL edge an_n cyc=%0d got=%b exp=%b", cyc, an_n, e_an); end
      if (seg_n !== e_seg) begin failures++; $display("FAIL edge seg_n cyc=%0d got=%h exp=%h", cyc, seg_n, e_seg); end
      if (dp_n !== e_dp) begin failures++; $display("FAIL edge dp_n cyc=%0d got=%b exp=%b", cyc, dp_n, e_dp); end
      if (load_ack !== e_ack) begin failures++; $display("FAIL edge load_ack cyc=%0d got=%b exp=%b", cyc, load_ack, e_ack); end
      load = (cyc == 287);
      step();
    end
    $display("test_commit_edge done checks=%0d failures=%0d", checks, failures);
  endtask

  // Reset during SHOW of digit 2 with 4444 pending: immediate blank, pending
  // dropped, scan restarts at digit 0 showing zeros.
  task automatic test_reset_mid();
    logic [3:0] e_an; logic [6:0] e_seg; logic e_dp;
    value = 16'h4444; dp_in = 4'b1111;
    while (cyc < 372) begin
      load = (cyc == 354);
      step();
    end
    checks += 2;
    if (an_n !== 4'b1011) begin failures++; $display("FAIL rstmid pre an_n got=%b exp=1011", an_n); end
    if (seg_n !== 7'h30) begin failures++; $display("FAIL rstmid pre seg_n got=%h exp=30", seg_n); end
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (an_n !== 4'hF) begin failures++; $display("FAIL rstmid an_n got=%b exp=1111", an_n); end
    if (seg_n !== 7'h7F) begin failures++; $display("FAIL rstmid seg_n got=%h exp=7f", seg_n); end
    if (dp_n !== 1'b1) begin failures++; $display("FAIL rstmid dp_n got=%b exp=1", dp_n); end
    if (load_ack !== 1'b0) begin failures++; $display("FAIL rstmid load_ack got=%b exp=0", load_ack); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      seg_old[i] = (i == 0) ? 7'h40 : 7'h7F;
      seg_new[i] = seg_old[i];
    end
    dp_old = 4'h0; dp_new = 4'h0;
    while (cyc < 64) begin
      e_an = exp_an(cyc); e_seg = exp_seg(cyc, 1000); e_dp = exp_dp(cyc, 1000);
      checks += 4;
      if (an_n !== e_an) begin failures++; $display("FAIL rstmid an_n cyc=%0d got=%b exp=%b", cyc, an_n, e_an); end
      if (seg_n !== e_seg) begin failures++; $display("FAIL rstmid seg_n cyc=%0d got=%h exp=%h", cyc, seg_n, e_seg); end
      if (dp_n !== e_dp) begin failures++; $display("FAIL rstmid dp_n cyc=%0d got=%b exp=%b", cyc, dp_n, e_dp); end
      if (load_ack !== 1'b0) begin failures++; $display("FAIL rstmid load_ack cyc=%0d got=%b exp=0", cyc, load_ack); end
      step();
    end
    $display("test_reset_mid done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_leading_zero();
    test_back_to_back();
    test_commit_edge();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
